// File: rtl/sound_noise_ctrl_if.sv
// CPU-side bus bundle for the noise channel control registers (NR41-NR44).
// The CPU decode drives through master; sound_noise_ctrl receives through slave.
interface sound_noise_ctrl_if;
   logic [15:0] addr;
   logic [7:0]  din;
   logic        wr;
   logic        rd;
   logic [7:0]  dout;

   modport master (output addr, output din, output wr, output rd, input dout);
   modport slave  (input addr, input din, input wr, input rd, output dout);
endinterface

// File: rtl/sound_noise_ctrl.sv
// Noise channel (sound channel 4) control front-end: NR41-NR44 registers, trigger pulse, frame-sequencer ticks.
// Define SOUND_NOISE_CTRL_READBACK_EN to enable register readback on dout; otherwise dout is constant 0xFF.
module sound_noise_ctrl #(
   parameter int FS_DIV             = 8192,
   parameter int START_PULSE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sound_en,
   sound_noise_ctrl_if.slave    bus,
   output logic [5:0]           length,
   output logic [3:0]           initial_volume,
   output logic                 envelope_increasing,
   output logic [2:0]           num_envelope_sweeps,
   output logic [3:0]           shift_clock_freq,
   output logic                 counter_width,
   output logic [2:0]           freq_dividing_ratio,
   output logic                 single,
   output logic                 start,
   output logic                 clk_length_ctr,
   output logic                 clk_vol_env
);

   localparam int DIV_W = $clog2(FS_DIV);
   localparam int CNT_W = $clog2(START_PULSE_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FS_DIV - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(START_PULSE_CYCLES);

   localparam logic [15:0] ADDR_NR41 = 16'hFF20;
   localparam logic [15:0] ADDR_NR42 = 16'hFF21;
   localparam logic [15:0] ADDR_NR43 = 16'hFF22;
   localparam logic [15:0] ADDR_NR44 = 16'hFF23;

   logic [CNT_W-1:0] pulse_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       step;
   logic [2:0]       next_step;
   logic             trigger;

   assign trigger   = bus.wr && (bus.addr == ADDR_NR44) && bus.din[7];
   assign next_step = step + 3'd1;
   assign start     = (pulse_cnt != '0);

   // With the master enable off the fields read as zero and writes are dropped.
   always_ff @(posedge clk) begin
      if (!rst || !sound_en) begin
         length              <= '0;
         initial_volume      <= '0;
         envelope_increasing <= 1'b0;
         num_envelope_sweeps <= '0;
         shift_clock_freq    <= '0;
         counter_width       <= 1'b0;
         freq_dividing_ratio <= '0;
         single              <= 1'b0;
      end else if (bus.wr) begin
         case (bus.addr)
            ADDR_NR41: length <= bus.din[5:0];
            ADDR_NR42: begin
               initial_volume      <= bus.din[7:4];
               envelope_increasing <= bus.din[3];
               num_envelope_sweeps <= bus.din[2:0];
            end
            ADDR_NR43: begin
               shift_clock_freq    <= bus.din[7:4];
               counter_width       <= bus.din[3];
               freq_dividing_ratio <= bus.din[2:0];
            end
            ADDR_NR44: single <= bus.din[6];
            default: ;
         endcase
      end
   end

   // A retrigger reloads the counter, stretching the pulse without a new rising edge.
   always_ff @(posedge clk) begin
      if (!rst || !sound_en) begin
         pulse_cnt <= '0;
      end else if (trigger) begin
         pulse_cnt <= PULSE_LOAD;
      end else if (pulse_cnt != '0) begin
         pulse_cnt <= pulse_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || !sound_en) begin
         div_cnt        <= '0;
         step           <= '0;
         clk_length_ctr <= 1'b0;
         clk_vol_env    <= 1'b0;
      end else begin
         clk_length_ctr <= 1'b0;
         clk_vol_env    <= 1'b0;
         if (div_cnt == DIV_LAST) begin
            div_cnt        <= '0;
            step           <= next_step;
            clk_length_ctr <= ~next_step[0];
            clk_vol_env    <= (next_step == 3'd7);
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

`ifdef SOUND_NOISE_CTRL_READBACK_EN
   logic [7:0] dout_q;

   // Sampled from the current register state, so a same-cycle write is not yet visible.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout_q <= 8'hFF;
      end else if (bus.rd) begin
         case (bus.addr)
            ADDR_NR42: dout_q <= {initial_volume, envelope_increasing, num_envelope_sweeps};
            ADDR_NR43: dout_q <= {shift_clock_freq, counter_width, freq_dividing_ratio};
            ADDR_NR44: dout_q <= {1'b1, single, 6'b111111};
            default:   dout_q <= 8'hFF;
         endcase
      end
   end

   assign bus.dout = dout_q;
`else
   assign bus.dout = 8'hFF;
`endif

endmodule

// File: tb/tb_sound_noise_ctrl.sv
// Directed self-checking bench for sound_noise_ctrl (FS_DIV = 16, START_PULSE_CYCLES = 4).
// Readback expectations follow SOUND_NOISE_CTRL_READBACK_EN when it is defined for the build.
module tb_sound_noise_ctrl;

   localparam int FS_DIV      = 16;
   localparam int PULSE_CYCLE = 4;

`ifdef SOUND_NOISE_CTRL_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       sound_en;
   logic [5:0] length;
   logic [3:0] initial_volume;
   logic       envelope_increasing;
   logic [2:0] num_envelope_sweeps;
   logic [3:0] shift_clock_freq;
   logic       counter_width;
   logic [2:0] freq_dividing_ratio;
   logic       single;
   logic       start;
   logic       clk_length_ctr;
   logic       clk_vol_env;

   int n_checks = 0;
   int n_fail   = 0;

   sound_noise_ctrl_if bus ();

   sound_noise_ctrl #(
      .FS_DIV             (FS_DIV),
      .START_PULSE_CYCLES (PULSE_CYCLE)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .sound_en            (sound_en),
      .bus                 (bus),
      .length              (length),
      .initial_volume      (initial_volume),
      .envelope_increasing (envelope_increasing),
      .num_envelope_sweeps (num_envelope_sweeps),
      .shift_clock_freq    (shift_clock_freq),
      .counter_width       (counter_width),
      .freq_dividing_ratio (freq_dividing_ratio),
      .single              (single),
      .start               (start),
      .clk_length_ctr      (clk_length_ctr),
      .clk_vol_env         (clk_vol_env)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rb(input logic [7:0] value);
      return READBACK ? value : 8'hFF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus cycle; returns one edge later with strobes released.
   task automatic apply_stimulus(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
      bus.wr   = w;
      bus.rd   = r;
      bus.addr = a;
      bus.din  = d;
      tick();
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   int len_edges[$];
   int vol_edges[$];
   int both_high;
   int found;

   initial begin
      rst      = 1'b0;
      sound_en = 1'b1;
      bus.wr   = 1'b0;
      bus.rd   = 1'b0;
      bus.addr = 16'h0000;
      bus.din  = 8'h00;

      // Reset and defaults
      repeat (3) tick();
      check_output("rst_length", length, 0);
      check_output("rst_start", start, 0);
      check_output("rst_dout", bus.dout, 8'hFF);
      check_output("rst_ticks", {clk_length_ctr, clk_vol_env}, 0);
      rst = 1'b1;
      tick();
      check_output("post_rst_nr43", {shift_clock_freq, counter_width, freq_dividing_ratio}, 0);
      apply_stimulus(1'b0, 1'b1, 16'hFF22, 8'h00);
      check_output("rd_ff22_reset", bus.dout, rb(8'h00));

      // Register writes
      apply_stimulus(1'b1, 1'b0, 16'hFF20, 8'h3A);
      apply_stimulus(1'b1, 1'b0, 16'hFF21, 8'hF3);
      apply_stimulus(1'b1, 1'b0, 16'hFF22, 8'h5C);
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'h40);
      check_output("length", length, 8'h3A);
      check_output("initial_volume", initial_volume, 4'hF);
      check_output("envelope_increasing", envelope_increasing, 0);
      check_output("num_envelope_sweeps", num_envelope_sweeps, 3);
      check_output("shift_clock_freq", shift_clock_freq, 5);
      check_output("counter_width", counter_width, 1);
      check_output("freq_dividing_ratio", freq_dividing_ratio, 4);
      check_output("single", single, 1);
      check_output("no_trigger_start", start, 0);

      // Readback
      apply_stimulus(1'b0, 1'b1, 16'hFF20, 8'h00);
      check_output("rd_ff20", bus.dout, 8'hFF);
      apply_stimulus(1'b0, 1'b1, 16'hFF21, 8'h00);
      check_output("rd_ff21", bus.dout, rb(8'hF3));
      tick();
      check_output("rd_hold", bus.dout, rb(8'hF3));
      apply_stimulus(1'b0, 1'b1, 16'hFF22, 8'h00);
      check_output("rd_ff22", bus.dout, rb(8'h5C));
      apply_stimulus(1'b0, 1'b1, 16'hFF23, 8'h00);
      check_output("rd_ff23", bus.dout, 8'hFF);
      apply_stimulus(1'b0, 1'b1, 16'hFF24, 8'h00);
      check_output("rd_unmapped", bus.dout, 8'hFF);
      apply_stimulus(1'b1, 1'b0, 16'hFF24, 8'h00);
      check_output("wr_unmapped_length", length, 8'h3A);
      apply_stimulus(1'b0, 1'b1, 16'hFF22, 8'h00);
      check_output("rd_ff22_after_unmapped", bus.dout, rb(8'h5C));

      // Same-cycle read and write returns the old value
      apply_stimulus(1'b1, 1'b1, 16'hFF21, 8'h18);
      check_output("rdwr_dout", bus.dout, rb(8'hF3));
      check_output("rdwr_nr42", {initial_volume, envelope_increasing, num_envelope_sweeps}, 8'h18);

      // Single trigger pulse: high N+1..N+4, low N+5
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'hC0);
      check_output("trig_single", single, 1);
      for (int i = 0; i < PULSE_CYCLE; i++) begin
         check_output($sformatf("trig_high_%0d", i + 1), start, 1);
         tick();
      end
      check_output("trig_low", start, 0);

      // Retrigger at N+2 stretches to N+6
      tick();
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'hC0);
      check_output("retrig_n1", start, 1);
      tick();
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'hC0);
      for (int i = 3; i <= 6; i++) begin
         check_output($sformatf("retrig_n%0d", i), start, 1);
         tick();
      end
      check_output("retrig_low", start, 0);

      // Master disable during a start pulse
      apply_stimulus(1'b1, 1'b0, 16'hFF20, 8'h2B);
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'hC0);
      check_output("dis_pre_start", start, 1);
      sound_en = 1'b0;
      tick();
      check_output("dis_start", start, 0);
      check_output("dis_length", length, 0);
      check_output("dis_nr43", {shift_clock_freq, counter_width, freq_dividing_ratio}, 0);
      check_output("dis_single", single, 0);
      apply_stimulus(1'b1, 1'b0, 16'hFF20, 8'h15);
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'hC0);
      check_output("dis_wr_length", length, 0);
      check_output("dis_wr_start", start, 0);
      apply_stimulus(1'b0, 1'b1, 16'hFF21, 8'h00);
      check_output("dis_rd_ff21", bus.dout, rb(8'h00));
      check_output("dis_ticks", {clk_length_ctr, clk_vol_env}, 0);

      // Re-enable: sequencer restarts from divider 0, step 0
      sound_en  = 1'b1;
      both_high = 0;
      for (int cyc = 1; cyc <= 260; cyc++) begin
         tick();
         if (clk_length_ctr) len_edges.push_back(cyc);
         if (clk_vol_env)    vol_edges.push_back(cyc);
         if (clk_length_ctr && clk_vol_env) both_high++;
      end
      check_output("len_tick_count", len_edges.size(), 8);
      for (int k = 0; k < len_edges.size() && k < 8; k++)
         check_output($sformatf("len_tick_%0d", k), len_edges[k], 32 * (k + 1));
      check_output("vol_tick_count", vol_edges.size(), 2);
      if (vol_edges.size() >= 2) begin
         check_output("vol_tick_0", vol_edges[0], 112);
         check_output("vol_tick_1", vol_edges[1], 240);
      end
      check_output("tick_overlap", both_high, 0);

      // Reset during a start pulse
      apply_stimulus(1'b1, 1'b0, 16'hFF21, 8'hA5);
      apply_stimulus(1'b0, 1'b1, 16'hFF21, 8'h00);
      check_output("pre_rst_dout", bus.dout, rb(8'hA5));
      apply_stimulus(1'b1, 1'b0, 16'hFF23, 8'hC0);
      check_output("pre_rst_start", start, 1);
      rst = 1'b0;
      tick();
      check_output("mid_rst_start", start, 0);
      check_output("mid_rst_single", single, 0);
      check_output("mid_rst_nr42", {initial_volume, envelope_increasing, num_envelope_sweeps}, 0);
      check_output("mid_rst_dout", bus.dout, 8'hFF);
      rst = 1'b1;

      // First tick after reset release, then reset right after that wrap
      found = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         tick();
         if (clk_length_ctr) begin
            found = cyc;
            break;
         end
      end
      check_output("rst_first_len_tick", found, 32);
      rst = 1'b0;
      tick();
      check_output("rst_after_wrap_ticks", {clk_length_ctr, clk_vol_env}, 0);
      check_output("rst_after_wrap_start", start, 0);
      rst = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
